// File: rtl/sd_pkg.sv
// Shared definitions for the SD card SPI path: FSM encoding and default sizing.
package sd_pkg;

    localparam int SPI_WIDTH = 16;
    localparam int SPI_DIV   = 4;
    localparam int SPI_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_TRAIL = 2'd3
    } spi_state_e;

    // Bits needed to count 0..width inclusive.
    function automatic int bits_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/spi_halfper_tick.sv
// Half-period timer: one-cycle tick every DIV clocks while enabled, held at zero otherwise.
import sd_pkg::*;

module spi_halfper_tick #(
    parameter int DIV   = SPI_DIV,
    parameter int CNT_W = SPI_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable_i,
    output logic tick_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!enable_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = enable_i && (cnt_q == LAST);

endmodule

// File: rtl/spi_master_engine.sv
// Mode-0 MSB-first SPI master: one WIDTH-bit full-duplex transfer per en rising edge,
// with a DIV-cycle lead-in and trail around the SCLK burst.
import sd_pkg::*;

module spi_master_engine #(
    parameter int WIDTH = SPI_WIDTH,
    parameter int DIV   = SPI_DIV,
    parameter int CNT_W = SPI_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] datain,
    input  logic             en,
    output logic [WIDTH-1:0] dataout,
    output logic             done,
    output logic             sclk,
    output logic             mosi,
    input  logic             miso,
    output logic             ss
);

    localparam int                BITS_W    = bits_w(WIDTH);
    localparam logic [BITS_W-1:0] BITS_FULL = BITS_W'(WIDTH);

    logic [1:0]        rst_sync_q;
    logic              rst_n_int;

    spi_state_e        state_q, state_d;
    logic              en_q;
    logic              start;
    logic              tick;

    logic [WIDTH-1:0]  tx_q, tx_d;
    logic [WIDTH-1:0]  rx_q, rx_d;
    logic [WIDTH-1:0]  dataout_q, dataout_d;
    logic [BITS_W-1:0] bits_q, bits_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              ss_q, ss_d;
    logic              done_q, done_d;

    // Reset takes effect at once but is released only on a clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync_q[1];

    assign start = en && !en_q && (state_q == ST_IDLE);

    spi_halfper_tick #(
        .DIV   (DIV),
        .CNT_W (CNT_W)
    ) u_tick (
        .clk      (clk),
        .rst_n    (rst_n_int),
        .enable_i (state_q != ST_IDLE),
        .tick_o   (tick)
    );

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_LEAD;
            ST_LEAD:  if (tick) state_d = ST_SHIFT;
            ST_SHIFT: if (tick && sclk_q && (bits_q == BITS_FULL)) state_d = ST_TRAIL;
            ST_TRAIL: if (tick) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_d      = tx_q;
        rx_d      = rx_q;
        bits_d    = bits_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        ss_d      = ss_q;
        done_d    = done_q;
        dataout_d = dataout_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    tx_d   = datain;
                    done_d = 1'b0;
                    ss_d   = 1'b0;
                    mosi_d = datain[WIDTH-1];
                    bits_d = '0;
                end
            end
            ST_LEAD: begin
                if (tick) begin
                    sclk_d = 1'b1;
                    rx_d   = {rx_q[WIDTH-2:0], miso};
                    bits_d = bits_q + BITS_W'(1);
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                        // The fall after the last sample has no next bit to present.
                        if (bits_q != BITS_FULL) begin
                            tx_d   = {tx_q[WIDTH-2:0], 1'b0};
                            mosi_d = tx_q[WIDTH-2];
                        end
                    end else begin
                        sclk_d = 1'b1;
                        rx_d   = {rx_q[WIDTH-2:0], miso};
                        bits_d = bits_q + BITS_W'(1);
                    end
                end
            end
            ST_TRAIL: begin
                if (tick) begin
                    ss_d      = 1'b1;
                    dataout_d = rx_q;
                    done_d    = 1'b1;
                    mosi_d    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            en_q      <= 1'b0;
            tx_q      <= '0;
            rx_q      <= '0;
            bits_q    <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b1;
            ss_q      <= 1'b1;
            done_q    <= 1'b0;
            dataout_q <= '0;
        end else begin
            en_q      <= en;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            bits_q    <= bits_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            ss_q      <= ss_d;
            done_q    <= done_d;
            dataout_q <= dataout_d;
        end
    end

    assign dataout = dataout_q;
    assign done    = done_q;
    assign sclk    = sclk_q;
    assign mosi    = mosi_q;
    assign ss      = ss_q;

endmodule
